// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: in-order {pc, instr} buffer between Fetch and Decode, DEPTH entries (optional macro FDQ_BYPASS_EN).
// Latency: 1 cycle push-to-head; 0 cycles through the bypass when FDQ_BYPASS_EN is defined and the queue is empty.
// Backpressure: in_ready drops when full (a same-cycle pop does not free the slot); flush discards all entries.
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic             fetch_complete,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [PTR_W:0]   count,
    output logic             drained
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [31:0]      mem_pc    [DEPTH];
    logic [31:0]      mem_instr [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             q_empty;
    logic             q_full;
    logic             bypass_vld;
    logic             bypass_take;
    logic             push;
    logic             pop;

    // Handshake qualification: flush overrides both sides, a bypassed entry is never stored.
    always_comb begin
        q_empty  = (count == '0);
        q_full   = (count == FULL_COUNT);
        in_ready = ~q_full;
`ifdef FDQ_BYPASS_EN
        bypass_vld = q_empty & in_valid & ~flush;
`else
        bypass_vld = 1'b0;
`endif
        bypass_take = bypass_vld & out_ready;
        push        = in_valid & in_ready & ~flush & ~bypass_take;
        pop         = ~q_empty & out_ready & ~flush;
    end

    // Head presentation: bypass path when empty, else storage; zeros whenever nothing is valid.
    always_comb begin
        out_valid = ~q_empty | bypass_vld;
        out_pc    = '0;
        out_instr = '0;
        if (bypass_vld) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else if (~q_empty) begin
            out_pc    = mem_pc[rd_ptr];
            out_instr = mem_instr[rd_ptr];
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push & ~pop) begin
                count <= count + CNT_ONE;
            end else if (pop & ~push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Entry storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= in_pc;
            mem_instr[wr_ptr] <= in_instr;
        end
    end

    // Sticky drained flag: Fetch is done and nothing is held or arriving.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drained <= 1'b0;
        end else if (fetch_complete & q_empty & ~push) begin
            drained <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed stimulus with a scoreboard of expected {pc, instr} outputs.
// Inputs change 1 ns after the rising edge; DUT outputs are sampled on the falling edge.
// The monitor pops the scoreboard on every Decode handshake; stimulus checks occupancy/flags.
module tb_fetch_decode_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             fetch_complete;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [PTR_W:0]   count;
    logic             drained;

    logic [63:0] exp_q [$];
    logic [63:0] mon_e;
    int vectors = 0;
    int errors  = 0;

    fetch_decode_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_instr       (in_instr),
        .fetch_complete (fetch_complete),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .count          (count),
        .drained        (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // addi-style encodings: pc 0 -> 0x00500093, pc 4 -> 0x00600093, ...
    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'h00500093 + (pc << 18);
    endfunction

    task automatic offer(input logic [31:0] pc, input logic expect_out);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins_of(pc);
        if (expect_out) exp_q.push_back({pc, ins_of(pc)});
    endtask

    // Monitor: every consumed head must match the oldest expected entry, idle head reads zero.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_output: got pc %0h instr %0h, required no output",
                             out_pc, out_instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_pc", out_pc, mon_e[63:32]);
                    chk("out_instr", out_instr, mon_e[31:0]);
                end
            end else if (!out_valid) begin
                chk("idle_out_pc", out_pc, 32'h0);
                chk("idle_out_instr", out_instr, 32'h0);
            end
        end
    end

    initial begin
        int exp_cnt [4];
        int exp_drn [4];
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        fetch_complete = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sample();
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_drained", 32'(drained), 0);

        // Fill with Decode stalled, then hold an extra entry while full.
        for (int i = 0; i < 4; i++) begin
            step();
            offer(32'(4 * i), 1'b1);
        end
        step();
        offer(32'h10, 1'b1);
        sample();
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_out_valid", 32'(out_valid), 1);
        chk("full_head_pc", out_pc, 32'h0);
        // Pop while full: no push that cycle, slot frees one cycle later.
        step();
        out_ready = 1'b1;
        sample();
        chk("full_pop_count", 32'(count), 4);
        chk("full_pop_in_ready", 32'(in_ready), 0);
        step();
        sample();
        chk("after_pop_count", 32'(count), 3);
        chk("after_pop_in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        sample();
        chk("drain_count", 32'(count), 0);
        chk("drain_out_valid", 32'(out_valid), 0);
        chk("drain_sb_empty", 32'(exp_q.size()), 0);

        // Streaming through the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            step();
            offer(32'h100 + 32'(4 * i), 1'b1);
            sample();
`ifdef FDQ_BYPASS_EN
            chk("stream_count", 32'(count), 0);
`else
            chk("stream_count", 32'(count), (i == 0) ? 0 : 1);
`endif
        end
        step();
        in_valid = 1'b0;
        repeat (2) step();
        sample();
        chk("stream_end_count", 32'(count), 0);
        chk("stream_sb_empty", 32'(exp_q.size()), 0);

        // Flush with two queued and a third offered: none of them may appear.
        step();
        out_ready = 1'b0;
        offer(32'h200, 1'b0);
        step();
        offer(32'h204, 1'b0);
        step();
        flush = 1'b1;
        offer(32'h208, 1'b0);
        sample();
        chk("flush_cycle_count", 32'(count), 2);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sample();
        chk("post_flush_count", 32'(count), 0);
        chk("post_flush_out_valid", 32'(out_valid), 0);
        repeat (3) step();
        sample();
        chk("post_flush_idle_count", 32'(count), 0);

`ifdef FDQ_BYPASS_EN
        // Empty queue, Decode ready: same-cycle delivery without storing.
        step();
        offer(32'h10, 1'b1);
        sample();
        chk("bypass_out_valid", 32'(out_valid), 1);
        chk("bypass_out_pc", out_pc, 32'h10);
        chk("bypass_count", 32'(count), 0);
        step();
        in_valid = 1'b0;
        sample();
        chk("bypass_after_count", 32'(count), 0);
`endif

        // fetch_complete with two queued: drained one cycle after count hits 0.
        step();
        out_ready = 1'b0;
        offer(32'h300, 1'b1);
        step();
        offer(32'h304, 1'b1);
        step();
        in_valid = 1'b0; fetch_complete = 1'b1; out_ready = 1'b1;
        exp_cnt = '{2, 1, 0, 0};
        exp_drn = '{0, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            if (k != 0) step();
            sample();
            chk("fc_count", 32'(count), 32'(exp_cnt[k]));
            chk("fc_drained", 32'(drained), 32'(exp_drn[k]));
        end
        step();
        fetch_complete = 1'b0;
        sample();
        chk("drained_sticky", 32'(drained), 1);

        // Asynchronous reset with three queued.
        step();
        out_ready = 1'b0;
        offer(32'h400, 1'b0);
        step();
        offer(32'h404, 1'b0);
        step();
        offer(32'h408, 1'b0);
        step();
        in_valid = 1'b0;
        sample();
        chk("pre_reset_count", 32'(count), 3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_out_valid", 32'(out_valid), 0);
        chk("async_rst_out_pc", out_pc, 32'h0);
        chk("async_rst_out_instr", out_instr, 32'h0);
        chk("async_rst_in_ready", 32'(in_ready), 1);
        chk("async_rst_drained", 32'(drained), 0);
        step();
        reset = 1'b0;
        sample();
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_out_valid", 32'(out_valid), 0);
        chk("final_sb_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
